// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the peripheral bus controller and its address
// decoder: region codes, slave indices, FSM state encoding, operation type
// and the default ACCESS timeout.
// ---------------------------------------------------------------------------
package bus_pkg;

    // Region codes: the value of addr[31:ADDR_MSB] that selects each slave.
    localparam int unsigned REGION_RAM = 0;
    localparam int unsigned REGION_LED = 1;
    localparam int unsigned REGION_AXI = 2;

    // Slave indices: bit position in the strobe/ready vectors and the
    // 32-bit slot in the packed read-data bus.
    localparam int unsigned SLV_RAM = 0;
    localparam int unsigned SLV_LED = 1;
    localparam int unsigned SLV_AXI = 2;
    localparam int unsigned NUM_SLV = 3;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/periph_addr_decode.sv
// ---------------------------------------------------------------------------
// periph_addr_decode
// Combinational region decode of a byte address.
//   addr      in  32  byte address; region = addr[31:ADDR_MSB]
//   sel       out 3   one-hot slave select ([0]=RAM, [1]=LED, [2]=AXI)
//   unmapped  out 1   region matches no slave (sel is then all zero)
// ---------------------------------------------------------------------------
module periph_addr_decode
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_MSB = 17
) (
    input  logic [31:0]        addr,
    output logic [NUM_SLV-1:0] sel,
    output logic               unmapped
);

    localparam int unsigned RW = 32 - ADDR_MSB;

    logic [RW-1:0] region;
    logic          unused_low;

    assign region     = addr[31:ADDR_MSB];
    // Offset bits inside a region play no part in the decode.
    assign unused_low = ^addr[ADDR_MSB-1:0];

    always_comb begin
        sel          = '0;
        sel[SLV_RAM] = (region == RW'(REGION_RAM));
        sel[SLV_LED] = (region == RW'(REGION_LED));
        sel[SLV_AXI] = (region == RW'(REGION_AXI));
        unmapped     = ~|sel;
    end

endmodule

// File: rtl/periph_bus_ctrl.sv
// ---------------------------------------------------------------------------
// periph_bus_ctrl
// Single-master to three-slave peripheral bus controller with region decode,
// per-access timeout and a saturating error counter.
//   clk_i          in  1   clock (rising edge)
//   rst_i          in  1   asynchronous, active-low reset
//   mst_rd_i/wr_i  in  1   master read / write request, held until ready
//   mst_addr_i     in  32  byte address
//   mst_data_i     in  32  write data
//   mst_be_i       in  4   byte enables
//   mst_ready_o    out 1   one-cycle completion pulse
//   mst_data_o     out 32  read data, valid with mst_ready_o, else 0
//   mst_err_o      out 1   error flag, valid with mst_ready_o, else 0
//   slv_rd_o/wr_o  out 3   per-slave strobes ([0]=RAM, [1]=LED, [2]=AXI)
//   slv_addr_o     out 32  latched address (shared)
//   slv_data_o     out 32  latched write data (shared)
//   slv_be_o       out 4   latched byte enables (shared)
//   slv_ready_i    in  3   per-slave completion
//   slv_rdata_i    in  96  per-slave read data, slave n at [32n+31:32n]
//   err_cnt_o      out 8   saturating count of errored completions
// ---------------------------------------------------------------------------
module periph_bus_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned ADDR_MSB       = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mst_rd_i,
    input  logic                  mst_wr_i,
    input  logic [31:0]           mst_addr_i,
    input  logic [31:0]           mst_data_i,
    input  logic [3:0]            mst_be_i,
    output logic                  mst_ready_o,
    output logic [31:0]           mst_data_o,
    output logic                  mst_err_o,
    output logic [NUM_SLV-1:0]    slv_rd_o,
    output logic [NUM_SLV-1:0]    slv_wr_o,
    output logic [31:0]           slv_addr_o,
    output logic [31:0]           slv_data_o,
    output logic [3:0]            slv_be_o,
    input  logic [NUM_SLV-1:0]    slv_ready_i,
    input  logic [32*NUM_SLV-1:0] slv_rdata_i,
    output logic [7:0]            err_cnt_o
);

    // Counter value seen in the last allowed ACCESS cycle (counter is 0 in
    // the first one).
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e             state_q;
    op_e                op_q;
    logic [NUM_SLV-1:0] sel_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [9:0]         tmo_cnt_q;
    logic [7:0]         err_cnt_q;

    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_unmapped;
    logic               sel_ready;
    logic [31:0]        sel_rdata;
    logic               req_one;
    logic               req_both;
    logic               done_err;

    periph_addr_decode #(
        .ADDR_MSB (ADDR_MSB)
    ) u_decode (
        .addr     (mst_addr_i),
        .sel      (dec_sel),
        .unmapped (dec_unmapped)
    );

    assign req_one  = mst_rd_i ^ mst_wr_i;
    assign req_both = mst_rd_i & mst_wr_i;

    // Only the latched slave is listened to; other ready lines are masked.
    assign sel_ready = |(slv_ready_i & sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | slv_rdata_i[32*i +: 32];
            end
        end
    end

    assign done_err = (state_q == ST_ERR) || ((state_q == ST_DONE) && err_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RD;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            tmo_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (done_err) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
            case (state_q)
                ST_IDLE: begin
                    // Conflicting rd+wr is rejected without touching slaves.
                    if (req_both) begin
                        state_q <= ST_ERR;
                    end else if (req_one) begin
                        addr_q    <= mst_addr_i;
                        wdata_q   <= mst_data_i;
                        be_q      <= mst_be_i;
                        op_q      <= mst_wr_i ? OP_WR : OP_RD;
                        sel_q     <= dec_sel;
                        tmo_cnt_q <= '0;
                        state_q   <= dec_unmapped ? ST_ERR : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Ready wins over a timeout expiring in the same cycle.
                    if (sel_ready) begin
                        rdata_q <= (op_q == OP_RD) ? sel_rdata : 32'd0;
                        err_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 10'd1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes are decoded from registered state so they stay steady for the
    // whole ACCESS phase and vanish as soon as reset asserts.
    assign slv_rd_o   = ((state_q == ST_ACCESS) && (op_q == OP_RD)) ? sel_q : '0;
    assign slv_wr_o   = ((state_q == ST_ACCESS) && (op_q == OP_WR)) ? sel_q : '0;
    assign slv_addr_o = addr_q;
    assign slv_data_o = wdata_q;
    assign slv_be_o   = be_q;

    assign mst_ready_o = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign mst_err_o   = done_err;
    assign mst_data_o  = (state_q == ST_DONE) ? rdata_q : 32'd0;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
module tb_periph_bus_ctrl;
    import bus_pkg::*;

    localparam int T    = 4;
    localparam int AMSB = 17;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        mst_rd_i = 1'b0, mst_wr_i = 1'b0;
    logic [31:0] mst_addr_i = '0, mst_data_i = '0;
    logic [3:0]  mst_be_i = '0;
    logic        mst_ready_o, mst_err_o;
    logic [31:0] mst_data_o;
    logic [2:0]  slv_rd_o, slv_wr_o;
    logic [31:0] slv_addr_o, slv_data_o;
    logic [3:0]  slv_be_o;
    logic [2:0]  slv_ready_i = '0;
    logic [95:0] slv_rdata_i = '0;
    logic [7:0]  err_cnt_o;

    periph_bus_ctrl #(.TIMEOUT_CYCLES(T), .ADDR_MSB(AMSB)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mst_rd_i(mst_rd_i), .mst_wr_i(mst_wr_i), .mst_addr_i(mst_addr_i),
        .mst_data_i(mst_data_i), .mst_be_i(mst_be_i),
        .mst_ready_o(mst_ready_o), .mst_data_o(mst_data_o), .mst_err_o(mst_err_o),
        .slv_rd_o(slv_rd_o), .slv_wr_o(slv_wr_o), .slv_addr_o(slv_addr_o),
        .slv_data_o(slv_data_o), .slv_be_o(slv_be_o),
        .slv_ready_i(slv_ready_i), .slv_rdata_i(slv_rdata_i), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          rdy;       // cycle the selected slave answers; 0 = never
        logic [31:0] rdata;
        logic [2:0]  exp_rd;    // expected read strobe while accessing
        logic [2:0]  exp_wr;    // expected write strobe while accessing
        int          exp_done;  // cycle of the completion pulse
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int exp_errcnt = 0;
    vec_t tbl[8];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be, input int rdy,
                                input logic [31:0] rdata, input logic [2:0] exp_rd,
                                input logic [2:0] exp_wr, input int exp_done,
                                input logic [31:0] exp_data, input logic exp_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
        v.rdy = rdy; v.rdata = rdata; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
        v.exp_done = exp_done; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    // Reference model: derives the expected outcome from the bus rules.
    function automatic vec_t model(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be,
                                   input int rdy, input logic [31:0] rdata);
        vec_t v;
        int unsigned region;
        bit ok;
        v = mk(rd, wr, addr, wdata, be, rdy, rdata, 3'b0, 3'b0, 1, 32'd0, 1'b1);
        region = addr >> AMSB;
        if ((rd && wr) || region > 2) return v;
        if (rd) v.exp_rd = 3'(1 << region);
        else    v.exp_wr = 3'(1 << region);
        ok = (rdy >= 1) && (rdy <= T);
        v.exp_done = ok ? rdy + 1 : T + 1;
        v.exp_err  = !ok;
        v.exp_data = (ok && rd) ? rdata : 32'd0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    // Entered just after a rising edge with the DUT idle; leaves it idle.
    task automatic run_txn(input vec_t v, input logic noise, input string name);
        logic [2:0] sel;
        sel = v.exp_rd | v.exp_wr;
        mst_rd_i = v.rd; mst_wr_i = v.wr; mst_addr_i = v.addr;
        mst_data_i = v.wdata; mst_be_i = v.be;
        for (int c = 1; c <= v.exp_done; c++) begin
            @(posedge clk_i); #1;
            chk({name, " rd_stb"}, 32'(slv_rd_o), 32'((c < v.exp_done) ? v.exp_rd : 3'b0));
            chk({name, " wr_stb"}, 32'(slv_wr_o), 32'((c < v.exp_done) ? v.exp_wr : 3'b0));
            chk({name, " ready"}, 32'(mst_ready_o), 32'(c == v.exp_done));
            chk({name, " data"}, mst_data_o, (c == v.exp_done) ? v.exp_data : 32'd0);
            chk({name, " err"}, 32'(mst_err_o), 32'((c == v.exp_done) && v.exp_err));
            if (c == 1 && sel != 3'b0) begin
                chk({name, " slv_addr"}, slv_addr_o, v.addr);
                chk({name, " slv_data"}, slv_data_o, v.wdata);
                chk({name, " slv_be"}, 32'(slv_be_o), 32'(v.be));
            end
            if (c == v.exp_done) begin
                mst_rd_i = 1'b0; mst_wr_i = 1'b0;
                slv_ready_i = '0;
            end else begin
                slv_ready_i = ((c == v.rdy) ? sel : 3'b0) |
                              (noise ? (3'($urandom) & ~sel) : 3'b0);
                for (int i = 0; i < 3; i++)
                    slv_rdata_i[32*i +: 32] = sel[i] ? v.rdata : $urandom;
            end
        end
        if (v.exp_err && exp_errcnt < 255) exp_errcnt++;
        @(posedge clk_i); #1;
        chk({name, " ready_after"}, 32'(mst_ready_o), 32'd0);
        chk({name, " err_cnt"}, 32'(err_cnt_o), 32'(exp_errcnt));
    endtask

    initial begin
        vec_t v;
        int unsigned region;
        logic rd, wr;

        // Hand-computed vectors (TIMEOUT_CYCLES = 4).
        tbl[0] = mk(1, 0, 32'h0000_0010, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 3'b001, 3'b000, 3, 32'hDEAD_BEEF, 0);
        tbl[1] = mk(0, 1, 32'h0002_0000, 32'h5, 4'hF, 1, 32'hFFFF_FFFF, 3'b000, 3'b010, 2, 32'h0, 0);
        tbl[2] = mk(1, 0, 32'h0006_0000, 32'h0, 4'hF, 1, 32'h1111_1111, 3'b000, 3'b000, 1, 32'h0, 1);
        tbl[3] = mk(1, 0, 32'h0004_0004, 32'h0, 4'hF, 0, 32'h2222_2222, 3'b100, 3'b000, 5, 32'h0, 1);
        tbl[4] = mk(1, 0, 32'h0004_0004, 32'h0, 4'h3, 4, 32'h1234_5678, 3'b100, 3'b000, 5, 32'h1234_5678, 0);
        tbl[5] = mk(1, 1, 32'h0000_0010, 32'h0, 4'hF, 1, 32'h3333_3333, 3'b000, 3'b000, 1, 32'h0, 1);
        tbl[6] = mk(0, 1, 32'h0004_0100, 32'hCAFE_0001, 4'h8, 3, 32'h4444_4444, 3'b000, 3'b100, 4, 32'h0, 0);
        tbl[7] = mk(0, 1, 32'h0001_FFFC, 32'h0000_00A5, 4'h1, 5, 32'h5555_5555, 3'b000, 3'b001, 5, 32'h0, 1);

        // Reset state, then release.
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst ready", 32'(mst_ready_o), 32'd0);
        chk("rst data", mst_data_o, 32'd0);
        chk("rst err", 32'(mst_err_o), 32'd0);
        chk("rst strobes", 32'({slv_rd_o, slv_wr_o}), 32'd0);
        chk("rst err_cnt", 32'(err_cnt_o), 32'd0);
        chk("rst slv_addr", slv_addr_o, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("idle ready", 32'(mst_ready_o), 32'd0);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        // Reset in the middle of an access: strobe drops at once, no pulse.
        mst_rd_i = 1'b1; mst_addr_i = 32'h0000_0100; mst_be_i = 4'hF;
        @(posedge clk_i); #1;
        chk("mid strobe", 32'(slv_rd_o), 32'd1);
        @(posedge clk_i); #3;
        rst_i = 1'b0;
        #1;
        chk("mid async strobe", 32'(slv_rd_o), 32'd0);
        chk("mid async ready", 32'(mst_ready_o), 32'd0);
        mst_rd_i = 1'b0;
        exp_errcnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("mid no pulse", 32'(mst_ready_o), 32'd0);
            chk("mid err_cnt", 32'(err_cnt_o), 32'd0);
        end
        rst_i = 1'b1;
        run_txn(mk(1, 0, 32'h0000_0100, 32'h0, 4'hF, 1, 32'h0BAD_F00D,
                   3'b001, 3'b000, 2, 32'h0BAD_F00D, 0), 1'b0, "post_rst");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            region = $urandom_range(0, 4);
            if (region == 4) region = $urandom_range(3, (1 << (32 - AMSB)) - 1);
            if ($urandom_range(0, 7) == 0) begin
                rd = 1'b1; wr = 1'b1;
            end else begin
                rd = 1'($urandom); wr = !rd;
            end
            v = model(rd, wr, (region << AMSB) | ($urandom & ((1 << AMSB) - 1)),
                      $urandom, 4'($urandom), $urandom_range(0, 6), $urandom);
            run_txn(v, 1'($urandom), $sformatf("rnd%0d", n));
        end

        // Error counter saturation, then a conflicting request.
        for (int n = 0; n < 300; n++) begin
            v = model(1'b1, 1'b0, 32'h0006_0000 | (32'($urandom) & 32'h1_FFFF),
                      32'h0, 4'hF, 1, 32'h0);
            run_txn(v, 1'b0, "sat");
        end
        chk("sat err_cnt", 32'(err_cnt_o), 32'd255);
        run_txn(mk(1, 1, 32'h0002_0000, 32'h7, 4'hF, 1, 32'h0, 3'b000, 3'b000, 1, 32'h0, 1),
                1'b0, "both");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/periph_bus_ctrl.md
PERIPH_BUS_CTRL -- requirements
Module: periph_bus_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: ACCESS cycles allowed before abort, range 1..1023.
REQ-002 Parameter ADDR_MSB, default 17: lowest address bit used for region decode (region = addr[31:ADDR_MSB]).
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous assert, active-low.
REQ-005 mst_rd_i  in  1  master read request, held until mst_ready_o.
REQ-006 mst_wr_i  in  1  master write request, held until mst_ready_o.
REQ-007 mst_addr_i  in  32  byte address.
REQ-008 mst_data_i  in  32  write data.
REQ-009 mst_be_i  in  4  byte enables.
REQ-010 mst_ready_o  out  1  one-cycle completion pulse.
REQ-011 mst_data_o  out  32  read data, valid with mst_ready_o.
REQ-012 mst_err_o  out  1  error flag, valid with mst_ready_o.
REQ-013 slv_rd_o  out  3  per-slave read strobe; [0]=RAM, [1]=LED, [2]=AXI.
REQ-014 slv_wr_o  out  3  per-slave write strobe.
REQ-015 slv_addr_o, slv_data_o, slv_be_o  out  32/32/4  latched request fields, shared by all slaves.
REQ-016 slv_ready_i  in  3  per-slave completion.
REQ-017 slv_rdata_i  in  96  per-slave read data, slave n at [32n+31:32n].
REQ-018 err_cnt_o  out  8  saturating count of errored transactions.

Function
REQ-019 States IDLE, ACCESS, DONE, ERR; reset state IDLE.
REQ-020 Region decode: 0 selects RAM, 1 selects LED, 2 selects AXI; any other value is unmapped.
REQ-021 IDLE with exactly one of mst_rd_i/mst_wr_i high: latch addr, data, be, op and slave index; go to ACCESS if mapped, ERR if unmapped.
REQ-022 IDLE with mst_rd_i and mst_wr_i both high: go to ERR, issue no slave strobe.
REQ-023 ACCESS: assert only the selected slave's strobe for the latched op, held steady every cycle until exit.
REQ-024 ACCESS with slv_ready_i[sel]=1: capture slv_rdata_i[sel] (reads only; writes capture 0), go to DONE, no error.
REQ-025 ACCESS: a timeout counter cleared on entry increments each cycle; at TIMEOUT_CYCLES without ready, drop the strobe, set error, go to DONE with data 0.
REQ-026 ACCESS: slv_ready_i of non-selected slaves is ignored.
REQ-027 DONE: mst_ready_o=1 for exactly one cycle with captured data and error; return to IDLE.
REQ-028 ERR: mst_ready_o=1, mst_err_o=1, mst_data_o=0 for one cycle; return to IDLE.
REQ-029 Requests are sampled only in IDLE; requests present in DONE or ERR are ignored.
REQ-030 Latency: request in IDLE at cycle 0, strobe from cycle 1, slave ready at cycle k>=1, mst_ready_o at cycle k+1.
REQ-031 Unmapped request: mst_ready_o at cycle 1.
REQ-032 mst_data_o and mst_err_o are 0 whenever mst_ready_o is 0.
REQ-033 err_cnt_o increments once per errored completion and saturates at 255.
REQ-034 A slave asserting ready in the same cycle the timeout expires counts as success (ready has priority).

Reset
REQ-035 rst_i low forces IDLE immediately, independent of clk_i.
REQ-036 During and after reset: all strobes 0, mst_ready_o 0, mst_data_o 0, mst_err_o 0, err_cnt_o 0, latches 0, timeout counter 0.
REQ-037 Reset during ACCESS aborts the transaction with no completion pulse.

Structure
REQ-038 Shared package bus_pkg holds region codes (RAM=0, LED=1, AXI=2), slave index constants, the state enum, and the default TIMEOUT_CYCLES.
REQ-039 Region decode is a separate combinational sub-module, periph_addr_decode: input address, outputs a one-hot 3-bit select and an unmapped flag.

Verification
REQ-040 Read 0x0000_0010, RAM ready 2 cycles after strobe with data 0xDEADBEEF -> slv_rd_o=001 until ready, then mst_ready_o one cycle with 0xDEADBEEF, err=0.
REQ-041 Write 0x0002_0000, data 0x5, be 0xF, LED ready 1 cycle after strobe -> slv_wr_o=010, slv_data_o=0x5, completion err=0, mst_data_o=0.
REQ-042 Read 0x0006_0000 (unmapped) -> no strobe, mst_ready_o at cycle 1 with err=1, data 0, err_cnt_o=1.
REQ-043 TIMEOUT_CYCLES=4, AXI read 0x0004_0004 never ready -> strobe 4 cycles, then completion err=1, data 0; AXI ready arriving exactly at cycle 4 -> err=0.
REQ-044 rst_i low mid-ACCESS -> strobes drop asynchronously, no mst_ready_o pulse; the next request completes normally after release.
REQ-045 300 unmapped accesses -> err_cnt_o=255; rd and wr both high -> ERR completion with no strobe.
